// File: rtl/intr_pkg.sv
// Shared mode encodings and edge-select helper for the interrupt edge controller.
package intr_pkg;

  typedef enum logic [1:0] {
    ModeLevel = 2'b00,
    ModeRise  = 2'b01,
    ModeFall  = 2'b10,
    ModeBoth  = 2'b11
  } intr_mode_e;

  function automatic logic edge_hit(input intr_mode_e mode, input logic s, input logic p);
    logic hit;
    case (mode)
      ModeRise: hit = s & ~p;
      ModeFall: hit = ~s & p;
      ModeBoth: hit = s ^ p;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/intr_edge_chan.sv
// One interrupt channel: synchronizer, history flop, event detect and sticky pending bit.
module intr_edge_chan
  import intr_pkg::*;
#(
  parameter int unsigned SYNC_STAGE = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       raw_intr,
  input  logic [1:0] mode,
  input  logic       detect_en,
  input  logic       clear,
  output logic       pending
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;
  logic [SYNC_STAGE-1:0] sync_d;
  logic                  s;
  logic                  p_q, p_d;
  logic                  pending_q, pending_d;
  logic                  evt;
  intr_mode_e            mode_e;

  assign mode_e  = intr_mode_e'(mode);
  assign s       = sync_q[SYNC_STAGE-1];
  assign pending = pending_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGE-2:0], raw_intr};
    p_d    = s;
    evt    = detect_en & edge_hit(mode_e, s, p_q);
    // An event in the same cycle as a clear wins, so no event is ever dropped.
    if (mode_e == ModeLevel) begin
      pending_d = s;
    end else begin
      pending_d = (pending_q & ~clear) | evt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q    <= '0;
      p_q       <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      p_q       <= p_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/intr_edge_ctrl.sv
// Multi-channel interrupt edge/level controller with masked level output and retriggerable pulse.
module intr_edge_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned INTR_WIDTH  = 1,
  parameter int unsigned SYNC_STAGE  = 2,
  parameter int unsigned PULSE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [INTR_WIDTH-1:0]   raw_intr,
  input  logic [2*INTR_WIDTH-1:0] mode,
  input  logic [INTR_WIDTH-1:0]   mask,
  input  logic [INTR_WIDTH-1:0]   clear,
  output logic [INTR_WIDTH-1:0]   pending,
  output logic                    intr_level,
  output logic                    intr_pulse
);

  localparam int unsigned CntW  = $clog2(PULSE_WIDTH + 1);
  localparam int unsigned WarmW = $clog2(SYNC_STAGE + 2);

  logic [WarmW-1:0]      warm_q, warm_d;
  logic                  detect_en;
  logic [INTR_WIDTH-1:0] masked;
  logic [INTR_WIDTH-1:0] masked_q, masked_d;
  logic                  level_q, level_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Hold off edge detection until the synchronizers and history flops hold real input data.
  assign detect_en = (warm_q == '0);

  for (genvar i = 0; i < INTR_WIDTH; i++) begin : g_chan
    intr_edge_chan #(
      .SYNC_STAGE(SYNC_STAGE)
    ) u_chan (
      .clk      (clk),
      .resetn   (resetn),
      .raw_intr (raw_intr[i]),
      .mode     (mode[2*i +: 2]),
      .detect_en(detect_en),
      .clear    (clear[i]),
      .pending  (pending[i])
    );
  end

  always_comb begin
    masked   = pending & mask;
    masked_d = masked;
    level_d  = |masked;
    warm_d   = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
    if (|(masked & ~masked_q)) begin
      cnt_d = CntW'(PULSE_WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      warm_q   <= WarmW'(SYNC_STAGE + 1);
      masked_q <= '0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      warm_q   <= warm_d;
      masked_q <= masked_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  assign intr_level = level_q;
  assign intr_pulse = (cnt_q != '0);

endmodule

// File: tb/tb_intr_edge_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a sample-history model.
module tb_intr_edge_ctrl;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int PW = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [W-1:0]   raw_intr = '0;
  logic [2*W-1:0] mode = '0;
  logic [W-1:0]   mask = '0;
  logic [W-1:0]   clear = '0;
  logic [W-1:0]   pending;
  logic           intr_level;
  logic           intr_pulse;

  int checks = 0;
  int failures = 0;

  intr_edge_ctrl #(
    .INTR_WIDTH (W),
    .SYNC_STAGE (SS),
    .PULSE_WIDTH(PW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .raw_intr  (raw_intr),
    .mode      (mode),
    .mask      (mask),
    .clear     (clear),
    .pending   (pending),
    .intr_level(intr_level),
    .intr_pulse(intr_pulse)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of raw samples (newest first); s lags SS-1 samples, p one more.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_pend;
  logic [W-1:0] m_prevm;
  logic         m_lvl;
  logic         m_pulse;
  int           nedge;
  int           last_rise;

  task automatic model_reset();
    m_pend    = '0;
    m_prevm   = '0;
    m_lvl     = 1'b0;
    m_pulse   = 1'b0;
    nedge     = 0;
    last_rise = -100;
    hist.delete();
    repeat (SS + 1) hist.push_front('0);
  endtask

  task automatic model_step();
    logic [W-1:0] s, p, nxt, msk;
    logic [1:0]   m;
    logic         ev;
    s = hist[SS-1];
    p = hist[SS];
    for (int ch = 0; ch < W; ch++) begin
      m = mode[2*ch +: 2];
      if (m == 2'b00) begin
        nxt[ch] = s[ch];
      end else begin
        if (m == 2'b01) ev = s[ch] && !p[ch];
        else if (m == 2'b10) ev = !s[ch] && p[ch];
        else ev = (s[ch] != p[ch]);
        ev = ev && (nedge >= SS + 1);
        nxt[ch] = (m_pend[ch] && !clear[ch]) || ev;
      end
    end
    msk   = m_pend & mask;
    m_lvl = |msk;
    nedge++;
    if ((msk & ~m_prevm) != '0) last_rise = nedge;
    m_prevm = msk;
    m_pend  = nxt;
    m_pulse = (nedge - last_rise) < PW;
    hist.push_front(raw_intr);
    void'(hist.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("pending", 32'(pending), 32'(m_pend));
    check("intr_level", 32'(intr_level), 32'(m_lvl));
    check("intr_pulse", 32'(intr_pulse), 32'(m_pulse));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pc, hi, first, rises;
    logic prevp;

    // Input already high through reset release must not register as an event.
    raw_intr = 4'b0001;
    mode     = 8'b0101_0101;
    mask     = 4'hF;
    cyc(3);
    resetn = 1'b1;
    pc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      pc += int'(intr_pulse);
    end
    check("warmup_pending", 32'(pending), 32'h0);
    check("warmup_pulse_cycles", 32'(pc), 32'd0);

    raw_intr = 4'b0000;
    cyc(5);

    // Rising event: pending after 3 edges, level after 4, 4-cycle pulse.
    raw_intr = 4'b0001;
    cyc(2);
    check("rise_pending_early", 32'(pending), 32'h0);
    cyc(1);
    check("rise_pending", 32'(pending), 32'h1);
    check("rise_level_early", 32'(intr_level), 32'd0);
    cyc(1);
    check("rise_level", 32'(intr_level), 32'd1);
    check("rise_pulse_start", 32'(intr_pulse), 32'd1);
    pc = 1;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      pc += int'(intr_pulse);
    end
    check("rise_pulse_cycles", 32'(pc), 32'd4);
    clear = 4'b0001;
    cyc(1);
    clear = '0;
    check("rise_clear", 32'(pending), 32'h0);

    // Falling mode; clear coinciding with an event leaves pending set.
    mode     = 8'b0101_0110;
    raw_intr = 4'b0000;
    cyc(3);
    check("fall_pending", 32'(pending[0]), 32'd1);
    raw_intr = 4'b0001;
    cyc(5);
    raw_intr = 4'b0000;
    cyc(2);
    clear = 4'b0001;
    cyc(1);
    clear = '0;
    check("fall_clear_vs_event", 32'(pending[0]), 32'd1);
    clear = 4'b0001;
    cyc(1);
    clear = '0;
    check("fall_clear", 32'(pending[0]), 32'd0);

    // Level mode on ch1: follows input with 3-cycle lag, ignores clear, one pulse.
    mode  = 8'b0101_0010;
    cyc(2);
    hi    = 0;
    first = -1;
    rises = 0;
    prevp = intr_pulse;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) raw_intr[1] = 1'b1;
      if (i == 10) raw_intr[1] = 1'b0;
      clear = (i >= 4 && i < 9) ? 4'b0010 : 4'b0000;
      cyc(1);
      if (pending[1]) begin
        hi++;
        if (first < 0) first = i + 1;
      end
      if (intr_pulse && !prevp) rises++;
      prevp = intr_pulse;
    end
    clear = '0;
    check("level_first", 32'(first), 32'd3);
    check("level_high_cycles", 32'(hi), 32'd10);
    check("level_pulse_count", 32'(rises), 32'd1);

    // Masked-off ch2 event produces no pulse; ch0 does; unmasking ch2 pulses again.
    mode = 8'b0101_0101;
    mask = 4'b0001;
    cyc(4);
    raw_intr[2] = 1'b1;
    pc    = 0;
    rises = 0;
    prevp = intr_pulse;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) raw_intr[0] = 1'b1;
      cyc(1);
      pc += int'(intr_pulse);
      if (intr_pulse && !prevp) rises++;
      prevp = intr_pulse;
    end
    check("mask_pending", 32'(pending), 32'h5);
    check("mask_pulse_cycles", 32'(pc), 32'd4);
    check("mask_pulse_count", 32'(rises), 32'd1);
    mask = 4'b0101;
    pc = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      pc += int'(intr_pulse);
    end
    check("unmask_pulse_cycles", 32'(pc), 32'd4);
    clear = 4'hF;
    cyc(1);
    clear = '0;
    mask  = 4'hF;
    cyc(3);

    // Reset mid-pulse clears everything at once; held-high inputs stay quiet afterwards.
    raw_intr[3] = 1'b1;
    cyc(4);
    check("rst_pulse_before", 32'(intr_pulse), 32'd1);
    cyc(1);
    #2 resetn = 1'b0;
    #1;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_level", 32'(intr_level), 32'd0);
    check("rst_pulse", 32'(intr_pulse), 32'd0);
    cyc(3);
    resetn = 1'b1;
    pc = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      pc += int'(intr_pulse) + int'(pending != '0) + int'(intr_level);
    end
    check("post_rst_quiet", 32'(pc), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < W; ch++) begin
        if ($urandom_range(0, 7) == 0) raw_intr[ch] = ~raw_intr[ch];
      end
      clear = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
      end
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_edge_ctrl.md
INTR_EDGE_CTRL -- requirements
Module: intr_edge_ctrl

Interface
REQ-001 SHALL have parameter INTR_WIDTH, default 1, number of interrupt channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGE, default 2, synchronizer depth per channel (2..4).
REQ-003 SHALL have parameter PULSE_WIDTH, default 4, output pulse length in clk cycles (1..16).
REQ-004 clk  input  1  sole clock; every flop is on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 raw_intr  input  INTR_WIDTH  asynchronous interrupt sources.
REQ-007 mode  input  2*INTR_WIDTH  per-channel detect mode, quasi-static: 00 level-high, 01 rising, 10 falling, 11 both edges.
REQ-008 mask  input  INTR_WIDTH  1 = channel enabled onto the aggregate outputs.
REQ-009 clear  input  INTR_WIDTH  single-cycle write-1-to-clear of pending bits.
REQ-010 pending  output  INTR_WIDTH  sticky per-channel event status, unmasked.
REQ-011 intr_level  output  1  registered OR of (pending AND mask).
REQ-012 intr_pulse  output  1  rising-edge-sensitive pulse, PULSE_WIDTH cycles, per new masked event.

Function
REQ-013 Each raw_intr bit SHALL pass through SYNC_STAGE flops marked ASYNC_REG; the last stage is the channel's synced level s.
REQ-014 A history flop p SHALL register s every cycle, independent of mode.
REQ-015 Event detect: rising = s & ~p; falling = ~s & p; selected per mode (01 rising, 10 falling, 11 rising|falling).
REQ-016 Edge modes: pending bit SHALL set on the cycle after a detected event and stay set until cleared.
REQ-017 Level mode (00): pending SHALL equal s delayed one cycle; clear SHALL have no effect.
REQ-018 Same-cycle event and clear on a channel SHALL leave pending set; events are never lost.
REQ-019 Latency: raw_intr transition stable before edge 0 -> pending changes after edge SYNC_STAGE+1; intr_level follows one cycle later.
REQ-020 intr_level SHALL deassert one cycle after the last masked pending bit clears or is masked off.
REQ-021 A 0->1 transition of any (pending & mask) bit SHALL load the pulse counter with PULSE_WIDTH; intr_pulse = (counter != 0); counter decrements to 0 and saturates.
REQ-022 A new masked pending rise while the counter is nonzero SHALL reload PULSE_WIDTH (retrigger, no extra gap).
REQ-023 Unmasking an already-pending channel SHALL count as a 0->1 transition and produce a pulse.
REQ-024 Mode changes SHALL NOT create events by themselves; p always tracks s.
REQ-025 Warm-up: for SYNC_STAGE+1 cycles after resetn release, event detection SHALL be suppressed so inputs already high do not produce rising events; level-mode pending is not suppressed.

Reset
REQ-026 When resetn is low, all sync flops, p, pending, intr_level, the pulse counter and intr_pulse SHALL be 0, and the warm-up counter SHALL be reloaded.
REQ-027 A reset asserted mid-pulse or with pending bits set SHALL clear them immediately, with no pulse after release unless a new event occurs after warm-up.

Structure
REQ-028 The mode encodings (LEVEL, RISE, FALL, BOTH) SHALL be defined as constants in shared package intr_pkg.
REQ-029 Per-channel logic (synchronizer, p, detect, pending) SHALL be one sub-module, intr_edge_chan, instantiated INTR_WIDTH times by a generate loop.
REQ-030 The warm-up counter, aggregation, and pulse counter SHALL be in the top level and shared by all channels.

Verification
REQ-031 SYNC_STAGE=2, mode=01; raw 0->1 after warm-up -> pending[0]=1 at edge 3, intr_level=1 at edge 4, intr_pulse high for 4 cycles.
REQ-032 mode=10; raw 1->0 -> pending set; clear[0] pulsed in the same cycle as a second falling event -> pending stays 1.
REQ-033 mode=00; raw held high 10 cycles then low -> pending high 10 cycles, lagging by 3; clear ignored; no second pulse while it is held.
REQ-034 INTR_WIDTH=4, mask=0001; events on ch2 and ch0 3 cycles apart -> pending=0101, one pulse retriggered by ch0 only; later writing mask=0101 -> a new 4-cycle pulse.
REQ-035 raw_intr=1 before and through reset release, mode=01 -> no pending and no pulse; a later 0->1 transition produces a normal event.
REQ-036 resetn asserted during cycle 2 of a pulse -> intr_pulse, intr_level, and pending go to 0 asynchronously and stay 0 after release.
